// File: rtl/icache_unit_if.sv
// Shared request type and the fetch/memory-side interface of the instruction cache.
// The cache sits on the slave modport; the fetch unit and the refill fabric sit on master.
package icache_pkg;
  localparam int ADDR_FIELD_WIDTH = 32;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'b00,
    ACC_READ  = 2'b01,
    ACC_WRITE = 2'b10
  } access_t;

  typedef struct packed {
    logic                        vld;
    access_t                     access_type;
    logic [ADDR_FIELD_WIDTH-1:0] addr;
    logic [63:0]                 data;
  } request_t;
endpackage

// Handshake: icache_req.vld is a one-cycle transfer with no ready; the requester
// must stop issuing once it sees icache_busy, but may land one more request in the
// cycle after busy rises (it samples busy a cycle late), which the cache absorbs in a
// one-entry skid. icache_rsp.vld, mem_req.vld and mem_rsp.vld are single-cycle
// pulses that are always accepted by their receiver.
interface icache_unit_if;
  import icache_pkg::*;

  request_t icache_req;
  request_t icache_rsp;
  logic     icache_busy;
  request_t mem_req;
  request_t mem_rsp;

  modport slave (
    input  icache_req,
    input  mem_rsp,
    output icache_rsp,
    output icache_busy,
    output mem_req
  );

  modport master (
    output icache_req,
    output mem_rsp,
    input  icache_rsp,
    input  icache_busy,
    input  mem_req
  );
endinterface

// File: rtl/icache_unit.sv
// Direct-mapped instruction cache: one 64-bit fetch word per line, single
// outstanding refill, one-entry skid for the request that lands while busy.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_unit
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = ADDR_FIELD_WIDTH,
  parameter int LINE_W    = 64
) (
  input  logic          clk,
  input  logic          reset,
  icache_unit_if.slave  bus,
  input  logic          invalidate,
  output logic          req_overflow,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count,
  output logic [1:0]    dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0]     miss_addr_q, miss_addr_d;
  logic                  skid_full_q, skid_full_d;
  logic [ADDR_W-1:0]     skid_addr_q, skid_addr_d;
  logic                  overflow_q, overflow_d;
  request_t              rsp_q, rsp_d;
  request_t              mem_req_q, mem_req_d;
  logic                  refill_we;

  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]     data_mem [NUM_LINES];

  // Lookup source: a parked skid request always goes before a fresh one.
  logic                  src_vld;
  logic [ADDR_W-1:0]     src_addr;
  logic [IDX_W-1:0]      src_idx;
  logic [TAG_W-1:0]      src_tag;
  logic                  lookup_hit;
  logic [IDX_W-1:0]      miss_idx;
  logic [TAG_W-1:0]      miss_tag;

  assign src_vld    = skid_full_q | bus.icache_req.vld;
  assign src_addr   = skid_full_q ? skid_addr_q : bus.icache_req.addr;
  assign src_idx    = src_addr[IDX_W-1:0];
  assign src_tag    = src_addr[ADDR_W-1:IDX_W];
  // A same-cycle invalidate wins over a lookup, so the access is treated as a miss.
  assign lookup_hit = valid_q[src_idx] && (tag_mem[src_idx] == src_tag) && !invalidate;
  assign miss_idx   = miss_addr_q[IDX_W-1:0];
  assign miss_tag   = miss_addr_q[ADDR_W-1:IDX_W];

  // Only vld/addr of the fetch request and vld/data of the refill are meaningful.
  logic unused_bits;
  assign unused_bits = ^{bus.icache_req.access_type, bus.icache_req.data,
                         bus.mem_rsp.access_type, bus.mem_rsp.addr};

  // Control registers; tag and data arrays are kept out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      skid_full_q <= 1'b0;
      skid_addr_q <= '0;
      overflow_q  <= 1'b0;
      rsp_q       <= '0;
      mem_req_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      skid_full_q <= skid_full_d;
      skid_addr_q <= skid_addr_d;
      overflow_q  <= overflow_d;
      rsp_q       <= rsp_d;
      mem_req_q   <= mem_req_d;
    end
  end

  // Refill write into the tag and data arrays.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.mem_rsp.data;
    end
  end

  // Next-state, skid management and registered response / refill request.
  always_comb begin
    state_d     = state_q;
    valid_d     = invalidate ? '0 : valid_q;
    miss_addr_d = miss_addr_q;
    skid_full_d = skid_full_q;
    skid_addr_d = skid_addr_q;
    overflow_d  = overflow_q;
    rsp_d       = '0;
    mem_req_d   = '0;
    refill_we   = 1'b0;

    // A request arriving while busy parks in the skid; one beyond that is lost.
    if (bus.icache_req.vld) begin
      if (skid_full_q) begin
        overflow_d = 1'b1;
      end else if (state_q != S_IDLE) begin
        skid_full_d = 1'b1;
        skid_addr_d = bus.icache_req.addr;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (src_vld) begin
          skid_full_d = 1'b0;
          if (lookup_hit) begin
            rsp_d.vld  = 1'b1;
            rsp_d.addr = src_addr;
            rsp_d.data = data_mem[src_idx];
          end else begin
            miss_addr_d = src_addr;
            state_d     = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        mem_req_d.vld         = 1'b1;
        mem_req_d.access_type = ACC_READ;
        mem_req_d.addr        = miss_addr_q;
        state_d               = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        // The refill lands even if invalidate fires while it is in flight.
        if (bus.mem_rsp.vld) begin
          refill_we          = 1'b1;
          valid_d[miss_idx]  = 1'b1;
          rsp_d.vld          = 1'b1;
          rsp_d.addr         = miss_addr_q;
          rsp_d.data         = bus.mem_rsp.data;
          state_d            = S_RESPOND;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.icache_rsp  = rsp_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.icache_busy = (state_q != S_IDLE) || skid_full_q;
  assign req_overflow    = overflow_q;
  assign dbg_state_o     = state_q;

`ifdef ICACHE_PERF_CNT_EN
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign hit_evt  = (state_q == S_IDLE) && src_vld && lookup_hit;
  assign miss_evt = (state_q == S_IDLE) && src_vld && !lookup_hit;

  // Saturating hit/miss counters; invalidate leaves them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_unit.sv
// Bench for icache_unit: a cycle table for cold miss, hit stream and conflict/skid,
// then hand sequences for overflow, invalidate and reset during a miss.
module tb_icache_unit;
  import icache_pkg::*;

  typedef struct {
    logic        req_vld;
    logic [31:0] req_addr;
    logic        mrsp_vld;
    logic [63:0] mrsp_data;
    logic        exp_busy;
    logic        exp_mem_vld;
    logic [31:0] exp_mem_addr;
    logic        exp_rsp_vld;
    logic [31:0] exp_rsp_addr;
    logic [63:0] exp_rsp_data;
  } vec_t;

  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] D10 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D11 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D00 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] D40 = 64'h4040_4040_4040_4040;
  localparam logic [63:0] D01 = 64'h0A0B_0C0D_0E0F_1011;
  localparam logic [63:0] DJ  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk;
  logic        reset_n;
  logic        invalidate;
  logic        req_overflow;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [1:0]  dbg_state;

  icache_unit_if bus_if ();

  icache_unit dut (
    .clk          (clk),
    .reset        (reset_n),
    .bus          (bus_if),
    .invalidate   (invalidate),
    .req_overflow (req_overflow),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .dbg_state_o  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          failures = 0;
  vec_t        vt [27];
  logic [95:0] exp_q [$];
  int          mem_req_cnt = 0;
  logic [31:0] last_mem_addr = '0;
  logic        last_busy = 1'b0;
  logic        last_rsp_vld = 1'b0;
  bit          auto_mem = 1'b0;
  bit          am_pend = 1'b0;
  logic [31:0] am_addr = '0;

  function automatic vec_t mk(int rv, int ra, int mv, logic [63:0] mdat, int eb,
                              int emv, int ema, int erv, int era, logic [63:0] erd);
    vec_t s;
    s.req_vld      = 1'(rv);
    s.req_addr     = 32'(ra);
    s.mrsp_vld     = 1'(mv);
    s.mrsp_data    = mdat;
    s.exp_busy     = 1'(eb);
    s.exp_mem_vld  = 1'(emv);
    s.exp_mem_addr = 32'(ema);
    s.exp_rsp_vld  = 1'(erv);
    s.exp_rsp_addr = 32'(era);
    s.exp_rsp_data = erd;
    return s;
  endfunction

  // Refill data produced by the bench memory model for a given address.
  function automatic logic [63:0] md(input logic [31:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a);
    bus_if.icache_req.vld  = v;
    bus_if.icache_req.addr = a;
  endtask

  // One cycle: sample at negedge (scoreboard + memory model), advance past posedge.
  task automatic tick();
    logic [95:0] e;
    @(negedge clk);
    last_busy    = bus_if.icache_busy;
    last_rsp_vld = bus_if.icache_rsp.vld;
    if (bus_if.icache_rsp.vld) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rsp", 64'(bus_if.icache_rsp.vld), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 64'(bus_if.icache_rsp.addr), 64'(e[95:64]));
        chk("sb_data", bus_if.icache_rsp.data, e[63:0]);
      end
    end
    if (bus_if.mem_req.vld) begin
      mem_req_cnt++;
      last_mem_addr = bus_if.mem_req.addr;
      am_pend       = 1'b1;
      am_addr       = bus_if.mem_req.addr;
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      bus_if.mem_rsp.vld  = am_pend;
      bus_if.mem_rsp.data = md(am_addr);
      am_pend             = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.icache_busy) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'(0));
    chk("drain_busy", 64'(bus_if.icache_busy), 64'(0));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus_if.icache_req.vld  = vt[i].req_vld;
      bus_if.icache_req.addr = vt[i].req_addr;
      bus_if.mem_rsp.vld     = vt[i].mrsp_vld;
      bus_if.mem_rsp.data    = vt[i].mrsp_data;
      @(negedge clk);
      chk($sformatf("r%0d_busy", i), 64'(bus_if.icache_busy), 64'(vt[i].exp_busy));
      chk($sformatf("r%0d_mem_vld", i), 64'(bus_if.mem_req.vld), 64'(vt[i].exp_mem_vld));
      chk($sformatf("r%0d_rsp_vld", i), 64'(bus_if.icache_rsp.vld), 64'(vt[i].exp_rsp_vld));
      if (vt[i].exp_mem_vld) begin
        chk($sformatf("r%0d_mem_addr", i), 64'(bus_if.mem_req.addr), 64'(vt[i].exp_mem_addr));
        chk($sformatf("r%0d_mem_type", i), 64'(bus_if.mem_req.access_type), 64'(ACC_READ));
      end
      if (vt[i].exp_rsp_vld) begin
        chk($sformatf("r%0d_rsp_addr", i), 64'(bus_if.icache_rsp.addr), 64'(vt[i].exp_rsp_addr));
        chk($sformatf("r%0d_rsp_data", i), bus_if.icache_rsp.data, vt[i].exp_rsp_data);
      end
      @(posedge clk);
      #1;
    end
    bus_if.icache_req = '0;
    bus_if.mem_rsp    = '0;
  endtask

  initial begin
    int base;
    int exp_hit;
    int exp_miss;

    //            rv ra    mv data  busy mv  maddr rv  raddr  rdata
    vt[0]  = mk(1, 'h10, 0, Z,   0,  0, 0,    0, 0,     Z);
    vt[1]  = mk(0, 0,    0, Z,   1,  0, 0,    0, 0,     Z);
    vt[2]  = mk(0, 0,    0, Z,   1,  1, 'h10, 0, 0,     Z);
    vt[3]  = mk(0, 0,    1, D10, 1,  0, 0,    0, 0,     Z);
    vt[4]  = mk(0, 0,    0, Z,   1,  0, 0,    1, 'h10,  D10);
    vt[5]  = mk(1, 'h11, 0, Z,   0,  0, 0,    0, 0,     Z);
    vt[6]  = mk(0, 0,    0, Z,   1,  0, 0,    0, 0,     Z);
    vt[7]  = mk(0, 0,    1, D11, 1,  1, 'h11, 0, 0,     Z);
    vt[8]  = mk(0, 0,    0, Z,   1,  0, 0,    1, 'h11,  D11);
    vt[9]  = mk(1, 'h10, 0, Z,   0,  0, 0,    0, 0,     Z);
    vt[10] = mk(1, 'h11, 0, Z,   0,  0, 0,    1, 'h10,  D10);
    vt[11] = mk(1, 'h10, 0, Z,   0,  0, 0,    1, 'h11,  D11);
    vt[12] = mk(0, 0,    1, DJ,  0,  0, 0,    1, 'h10,  D10);
    vt[13] = mk(0, 0,    0, Z,   0,  0, 0,    0, 0,     Z);
    vt[14] = mk(1, 'h00, 0, Z,   0,  0, 0,    0, 0,     Z);
    vt[15] = mk(0, 0,    0, Z,   1,  0, 0,    0, 0,     Z);
    vt[16] = mk(0, 0,    1, D00, 1,  1, 'h00, 0, 0,     Z);
    vt[17] = mk(0, 0,    0, Z,   1,  0, 0,    1, 'h00,  D00);
    vt[18] = mk(1, 'h40, 0, Z,   0,  0, 0,    0, 0,     Z);
    vt[19] = mk(1, 'h01, 0, Z,   1,  0, 0,    0, 0,     Z);
    vt[20] = mk(0, 0,    1, D40, 1,  1, 'h40, 0, 0,     Z);
    vt[21] = mk(0, 0,    0, Z,   1,  0, 0,    1, 'h40,  D40);
    vt[22] = mk(0, 0,    0, Z,   1,  0, 0,    0, 0,     Z);
    vt[23] = mk(0, 0,    0, Z,   1,  0, 0,    0, 0,     Z);
    vt[24] = mk(0, 0,    1, D01, 1,  1, 'h01, 0, 0,     Z);
    vt[25] = mk(0, 0,    0, Z,   1,  0, 0,    1, 'h01,  D01);
    vt[26] = mk(0, 0,    0, Z,   0,  0, 0,    0, 0,     Z);

    // Reset
    reset_n           = 1'b0;
    invalidate        = 1'b0;
    bus_if.icache_req = '0;
    bus_if.mem_rsp    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus_if.icache_busy), 64'(0));
    chk("rst_rsp_vld", 64'(bus_if.icache_rsp.vld), 64'(0));
    chk("rst_mem_vld", 64'(bus_if.mem_req.vld), 64'(0));
    chk("rst_overflow", 64'(req_overflow), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    chk("rst_hit_count", 64'(hit_count), 64'(0));
    chk("rst_miss_count", 64'(miss_count), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Cold misses on 0x10/0x11, then three back-to-back hits
    run_rows(0, 13);
`ifdef ICACHE_PERF_CNT_EN
    exp_hit  = 3;
    exp_miss = 2;
`else
    exp_hit  = 0;
    exp_miss = 0;
`endif
    chk("perf_hit_count", 64'(hit_count), 64'(exp_hit));
    chk("perf_miss_count", 64'(miss_count), 64'(exp_miss));

    // Conflict on index 0 with a request parked in the skid
    run_rows(14, 26);
    chk("skid_no_overflow", 64'(req_overflow), 64'(0));

    // Overflow: third request while the skid is full is dropped
    auto_mem = 1'b1;
    base     = mem_req_cnt;
    exp_q.push_back({32'h80, md(32'h80)});
    exp_q.push_back({32'h02, md(32'h02)});
    drive_req(1'b1, 32'h80); tick();
    drive_req(1'b1, 32'h02); tick();
    drive_req(1'b1, 32'h03); tick();
    drive_req(1'b0, 32'h0);
    wait_drain(40);
    chk("ovf_set", 64'(req_overflow), 64'(1));
    chk("ovf_mem_reqs", 64'(mem_req_cnt - base), 64'(2));

    // Invalidate during MISS_WAIT: the in-flight refill still lands
    exp_q.push_back({32'h20, md(32'h20)});
    drive_req(1'b1, 32'h20); tick();
    drive_req(1'b0, 32'h0);  tick();
    chk("inv_in_wait_state", 64'(dbg_state), 64'(2));
    invalidate = 1'b1; tick();
    invalidate = 1'b0;
    wait_drain(20);

    // 0x20 now hits with single-cycle latency
    base = mem_req_cnt;
    exp_q.push_back({32'h20, md(32'h20)});
    drive_req(1'b1, 32'h20); tick();
    drive_req(1'b0, 32'h0);  tick();
    chk("hit20_rsp_next_cycle", 64'(last_rsp_vld), 64'(1));
    chk("hit20_not_busy", 64'(last_busy), 64'(0));
    wait_drain(5);
    chk("hit20_no_mem_req", 64'(mem_req_cnt - base), 64'(0));

    // 0x10 was cleared by the invalidate and must refetch
    base = mem_req_cnt;
    exp_q.push_back({32'h10, md(32'h10)});
    drive_req(1'b1, 32'h10); tick();
    drive_req(1'b0, 32'h0);  tick();
    chk("miss10_busy", 64'(last_busy), 64'(1));
    wait_drain(20);
    chk("miss10_mem_addr", 64'(last_mem_addr), 64'h10);
    chk("miss10_mem_reqs", 64'(mem_req_cnt - base), 64'(1));

    // Invalidate in the same cycle as a lookup of a valid line forces a miss
    base = mem_req_cnt;
    exp_q.push_back({32'h10, md(32'h10)});
    drive_req(1'b1, 32'h10);
    invalidate = 1'b1; tick();
    invalidate = 1'b0;
    drive_req(1'b0, 32'h0); tick();
    chk("inv_lookup_busy", 64'(last_busy), 64'(1));
    wait_drain(20);
    chk("inv_lookup_mem_reqs", 64'(mem_req_cnt - base), 64'(1));
    chk("ovf_sticky", 64'(req_overflow), 64'(1));

    // Reset mid-miss with a parked skid request and a late refill response
    drive_req(1'b1, 32'h30); tick();
    drive_req(1'b1, 32'h31); tick();
    drive_req(1'b0, 32'h0);  tick();
    chk("pre_rst_state", 64'(dbg_state), 64'(2));
    reset_n = 1'b0;
    #2;
    chk("mid_rst_busy", 64'(bus_if.icache_busy), 64'(0));
    reset_n = 1'b1;
    base    = mem_req_cnt;
    repeat (6) tick();
    chk("post_rst_busy", 64'(bus_if.icache_busy), 64'(0));
    chk("post_rst_state", 64'(dbg_state), 64'(0));
    chk("post_rst_overflow", 64'(req_overflow), 64'(0));
    chk("post_rst_mem_reqs", 64'(mem_req_cnt - base), 64'(0));
    chk("post_rst_hit_count", 64'(hit_count), 64'(0));
    chk("post_rst_miss_count", 64'(miss_count), 64'(0));

    // Normal service resumes after reset
    exp_q.push_back({32'h31, md(32'h31)});
    drive_req(1'b1, 32'h31); tick();
    drive_req(1'b0, 32'h0);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_unit.md
Name: icache_unit

Overview:
- Direct-mapped instruction cache; the responder end of the ifetch→icache request interface.
- Accepts one request_t per cycle from the fetch unit and returns 64-bit fetch words (two 32-bit opcodes) on a request_t response.
- Raises busy while servicing a miss; refills lines from the memory/fabric over a request_t read port.

Parameters:
NUM_LINES, 64, number of cache lines (power of 2); IDX_W = log2(NUM_LINES)
ADDR_W, ADDR_FIELD_WIDTH, width of request addr field; addr is a 64-bit-word index
LINE_W, 64, bits per line = one fetch word

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
icache_req  input  request_t  fetch request; vld, addr used, other fields ignored
icache_rsp  output  request_t  fetch response; vld single-cycle pulse
icache_busy  output  1  cache cannot take a new request next cycle
invalidate  input  1  one-cycle pulse: clear all valid bits
mem_req  output  request_t  refill read request, single-cycle pulse
mem_rsp  input  request_t  refill data; vld, data[63:0] used
req_overflow  output  1  sticky: request dropped (protocol violation)
hit_count  output  32  hit counter (see Optional Feature)
miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Reset (async, active-low): all outputs 0, all valid bits 0, state IDLE, skid empty, overflow 0. Tag/data arrays need no reset.
- Indexing: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- FSM states:
  - IDLE: source = skid if full, else icache_req if vld.
    - Hit: next cycle icache_rsp.vld=1, data=line, addr=request addr, all other fields 0. Back-to-back hits sustain one response per cycle.
    - Miss: latch addr, go to MISS_REQ.
  - MISS_REQ: drive mem_req for one cycle: vld=1, access_type=READ, addr=missing addr, other fields 0. Go to MISS_WAIT.
  - MISS_WAIT: hold until mem_rsp.vld. Then write data/tag, set valid, go to RESPOND.
  - RESPOND: icache_rsp pulse with refill data and latched addr. Return to IDLE.
- Response latency: hit 1 cycle; miss 3 + memory latency cycles.
- icache_busy = (state != IDLE) || skid full. It is combinational from registered state.
- Skid buffer (1 entry): the fetch unit samples busy one cycle late, so one extra request can arrive while busy.
  - A request arriving with state != IDLE and skid empty is captured into the skid.
  - A request arriving while the skid is full is dropped and sets req_overflow (sticky until reset).
  - An IDLE-state arrival while the skid is full is also captured-or-dropped by this rule; the skid is served first.
- Responses are always returned in request order.
- invalidate:
  - Clears all valid bits at the clock edge.
  - A lookup in the same cycle treats the access as a miss.
  - During MISS_WAIT, the in-flight refill still completes and marks its line valid.
- mem_rsp.vld outside MISS_WAIT is ignored. This covers a late response after reset.
- Reset mid-miss: the FSM returns to IDLE and the skid is discarded; no response is issued.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: hit_count increments on each IDLE hit and miss_count on each miss entry. Both are 32-bit, saturate at 0xFFFF_FFFF, reset to 0, and are not cleared by invalidate.
- Undefined: no counter logic is built and hit_count/miss_count are tied to 0.

Test Plan:
- Cold miss: req addr=0x10 → mem_req.addr=0x10 two cycles later. mem_rsp data=0xAAAA_BBBB_CCCC_DDDD → icache_rsp.vld one cycle later with that data, addr=0x10. Busy high from the cycle after the request until RESPOND completes.
- Hit stream: after filling 0x10 and 0x11, issue reqs 0x10, 0x11, 0x10 on consecutive cycles → 3 consecutive rsp pulses with correct data; busy stays 0.
- Conflict plus skid:
  - Fill index 0 with addr 0x00, then request 0x40 (same index, NUM_LINES=64) followed one cycle later by request 0x01.
  - Expect a miss on 0x40 and request 0x01 held in the skid.
  - Responses arrive for 0x40 then 0x01, in order; req_overflow stays 0.
- Overflow: present a third request while the skid is full → that request gets no response and req_overflow=1 until reset.
- Invalidate:
  - Pulse invalidate during MISS_WAIT for 0x20 → 0x20 is refilled and a later 0x20 access hits.
  - A prior line 0x10 then misses (mem_req issued).
- Perf counters with ICACHE_PERF_CNT_EN: after the hit-stream test → hit_count=3, miss_count=2. Without the macro → both 0.
